// File: rtl/spram_pkg.sv
// Shared types and default widths for the single-port RAM port master.
package spram_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH = 5;

   typedef enum logic {StInit, StRun} state_e;

   typedef struct packed {
      logic                      we;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } req_t;

endpackage

// File: rtl/spram_rsp_fifo.sv
// Response FIFO for read data; push and pop in the same edge are legal at any fill level.
module spram_rsp_fifo #(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned RSP_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic [DATA_WIDTH-1:0]            push_data,
   input  logic                             pop,
   output logic [DATA_WIDTH-1:0]            head,
   output logic [$clog2(RSP_DEPTH+1)-1:0]   count,
   output logic                             empty
);

   localparam int unsigned PW = $clog2(RSP_DEPTH);
   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  do_pop;

   assign empty  = (count == '0);
   assign do_pop = pop & ~empty;
   assign head   = mem[rd_ptr];

   // Storage, wrapping pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RSP_DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         if (push && !do_pop) begin
            count <= count + CW'(1);
         end else if (!push && do_pop) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/spram_port_master.sv
// Initiator for a single-port RAM: request stream in, RAM pins out, in-order read responses back.
module spram_port_master
   import spram_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned           RD_LAT     = 1,
   parameter int unsigned           RSP_DEPTH  = 4,
   parameter bit                    INIT_EN    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_out,
   output logic                  init_done
);

   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   state_e                state;
   logic [ADDR_WIDTH-1:0] ic;
   // Stage 0 covers the cycle the address sits in ram_addr; the last stage marks valid ram_out.
   logic [RD_LAT:0]       rd_pipe;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic                  accept;
   logic                  pop;
   logic                  credit;
   int unsigned           inflight;

   assign accept    = req_valid & req_ready;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_valid = ~fifo_empty;
   assign req_ready = (state == StRun) & credit;

   // Credit: every read accepted but not yet popped holds one FIFO slot.
   always_comb begin
      inflight = 0;
      for (int i = 0; i <= int'(RD_LAT); i++) begin
         inflight = inflight + 32'(rd_pipe[i]);
      end
      credit = (32'(fifo_count) + inflight) < RSP_DEPTH;
   end

   // Fill sequence, then registered RAM pins driven from accepted requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT_EN ? StInit : StRun;
         init_done <= ~INIT_EN;
         ic        <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
      end else begin
         unique case (state)
            StInit: begin
               ram_we   <= 1'b1;
               ram_addr <= ic;
               ram_data <= INIT_VALUE;
               ic       <= ic + ADDR_WIDTH'(1);
               if (ic == {ADDR_WIDTH{1'b1}}) begin
                  state     <= StRun;
                  init_done <= 1'b1;
               end
            end
            StRun: begin
               if (accept) begin
                  ram_we   <= req_we;
                  ram_addr <= req_addr;
                  ram_data <= req_data;
               end else begin
                  ram_we <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Read tag pipe; a tag leaving the last stage captures ram_out into the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe <= {rd_pipe[RD_LAT-1:0], accept & ~req_we};
      end
   end

   spram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .RSP_DEPTH  (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pipe[RD_LAT]),
      .push_data (ram_out),
      .pop       (pop),
      .head      (rsp_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_spram_port_master.sv
// Randomised and directed bench for spram_port_master against a transaction-level model.
module tb_spram_port_master;

   localparam int unsigned AW     = 5;
   localparam int unsigned DW     = 5;
   localparam int unsigned RD_LAT = 1;
   localparam int unsigned DEPTH  = 4;
   localparam int          NWORDS = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_we;
   logic [DW-1:0] ram_out;
   logic          init_done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   spram_port_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LAT     (RD_LAT),
      .RSP_DEPTH  (DEPTH),
      .INIT_EN    (1'b1),
      .INIT_VALUE ('0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_we    (ram_we),
      .ram_out   (ram_out),
      .init_done (init_done)
   );

   // Behavioural single-port RAM, one-cycle read latency, seeded with garbage.
   logic [DW-1:0] ram_mem [NWORDS];
   initial begin
      for (int i = 0; i < NWORDS; i++) ram_mem[i] <= DW'($urandom);
   end
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      ram_out <= ram_mem[ram_addr];
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: contents the RAM should hold and the reads still owed, in order.
   typedef struct {
      logic [DW-1:0] d;
      int            a;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] shadow [NWORDS];
   int            rel;
   int            n_pops = 0;
   logic          acc_pending;
   logic          acc_we;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_data;

   // Edges since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rel <= 0;
      else if (rel < 1000000) rel <= rel + 1;
   end

   // Mid-cycle monitor: compare outputs to the model, then log the handshakes of the next edge.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         acc_pending = 1'b0;
         for (int i = 0; i < NWORDS; i++) shadow[i] = '0;
      end else begin
         if (rel == 0) begin
            check("pre_init_we", int'(ram_we), 0);
            check("pre_init_done", int'(init_done), 0);
         end else if (rel <= NWORDS) begin
            check("init_we", int'(ram_we), 1);
            check("init_addr", int'(ram_addr), rel - 1);
            check("init_data", int'(ram_data), 0);
            check("init_done", int'(init_done), int'(rel == NWORDS));
         end else begin
            check("run_done", int'(init_done), 1);
            check("run_we", int'(ram_we), int'(acc_pending && acc_we));
            if (acc_pending) begin
               check("run_addr", int'(ram_addr), int'(acc_addr));
               if (acc_we) check("run_data", int'(ram_data), int'(acc_data));
            end
         end
         check("req_ready", int'(req_ready), int'(rel >= NWORDS && q.size() < DEPTH));
         check("rsp_valid", int'(rsp_valid),
               int'(q.size() > 0 && rel >= q[0].a + int'(RD_LAT) + 1));
         if (q.size() > 0 && rel >= q[0].a + int'(RD_LAT) + 1)
            check("rsp_data", int'(rsp_data), int'(q[0].d));

         acc_pending = req_valid && req_ready;
         acc_we      = req_we;
         acc_addr    = req_addr;
         acc_data    = req_data;
         if (req_valid && req_ready) begin
            if (req_we) shadow[req_addr] = req_data;
            else q.push_back('{d: shadow[req_addr], a: rel + 1});
         end
         if (rsp_valid && rsp_ready) begin
            n_pops++;
            if (q.size() > 0) void'(q.pop_front());
            else check("pop_unexpected", 1, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int stalls);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_data  = d;
      stalls    = 0;
      while (!req_ready && stalls < 200) begin
         tick();
         stalls++;
      end
      if (!req_ready) check("send_timeout", int'(req_ready), 1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      if (!rsp_valid) check("rsp_timeout", int'(rsp_valid), 1);
   endtask

   task automatic wait_init(input string tag);
      int cnt;
      cnt = 0;
      while (!init_done && cnt < 200) begin
         tick();
         cnt++;
      end
      check(tag, cnt, NWORDS);
   endtask

   task automatic drain();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 60 && (q.size() > 0 || rsp_valid); c++) tick();
      check("drain_model", q.size(), 0);
      check("drain_valid", int'(rsp_valid), 0);
      rsp_ready = 1'b0;
   endtask

   // Issue back-to-back reads with rsp_ready low until four are accepted.
   task automatic fill_credit();
      int acc;
      acc       = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'($urandom);
      for (int c = 0; c < 20 && acc < int'(DEPTH); c++) begin
         if (req_ready) acc++;
         tick();
         req_addr = AW'($urandom);
      end
      req_valid = 1'b0;
      check("fill_accepts", acc, int'(DEPTH));
   endtask

   initial begin
      int s;
      int tot;
      int acc;
      int n;
      int pops0;

      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      rsp_ready = 1'b0;

      // Reset values, applied asynchronously before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_ram_we", int'(ram_we), 0);
      check("rst_init_done", int'(init_done), 0);
      check("rst_ram_addr", int'(ram_addr), 0);
      check("rst_ram_data", int'(ram_data), 0);
      check("rst_rsp_data", int'(rsp_data), 0);
      repeat (3) tick();
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_init("init_cycles");
      check("init_ready", int'(req_ready), 1);

      // Read of a filled address.
      rsp_ready = 1'b1;
      send(1'b0, AW'(7), '0, s);
      wait_rsp(n);
      check("rd7_data", int'(rsp_data), 0);
      drain();

      // Write then read of the same address on consecutive edges.
      rsp_ready = 1'b1;
      send(1'b1, AW'(3), DW'(5'h15), s);
      send(1'b0, AW'(3), '0, s);
      wait_rsp(n);
      check("wr_rd_lat", n, 2);
      check("wr_rd_data", int'(rsp_data), 'h15);
      drain();

      // Streaming writes then reads at full rate.
      rsp_ready = 1'b1;
      tot = 0;
      for (int a = 0; a < NWORDS; a++) begin
         send(1'b1, AW'(a), DW'(a ^ 32'h0A), s);
         tot += s;
      end
      for (int a = 0; a < NWORDS; a++) begin
         send(1'b0, AW'(a), '0, s);
         tot += s;
      end
      check("stream_stalls", tot, 0);
      drain();

      // Backpressure: six reads with the consumer stalled.
      rsp_ready = 1'b0;
      acc       = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = '0;
      for (int c = 0; c < 10; c++) begin
         if (req_ready) acc++;
         tick();
         req_addr = AW'(acc);
      end
      check("bp_accepts", acc, 4);
      check("bp_ready_low", int'(req_ready), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_ready_back", int'(req_ready), 1);
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && acc < 6; c++) begin
         if (req_ready) acc++;
         tick();
         req_addr = AW'(acc);
      end
      check("bp_total", acc, 6);
      drain();

      // Pop on the same edge the final capture lands, with all credit in use.
      fill_credit();
      tick();
      pops0     = n_pops;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("pp_ready", int'(req_ready), 1);
      check("pp_valid", int'(rsp_valid), 1);
      drain();
      check("pp_pops", n_pops - pops0, 4);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = AW'($urandom);
         req_data  = DW'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain();

      // Reset with reads in flight and data queued.
      fill_credit();
      check("mr_valid_before", int'(rsp_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_rsp_valid", int'(rsp_valid), 0);
      check("mr_req_ready", int'(req_ready), 0);
      check("mr_init_done", int'(init_done), 0);
      check("mr_ram_we", int'(ram_we), 0);
      repeat (3) tick();
      @(posedge clk);
      #2 rst_n = 1'b1;
      rsp_ready = 1'b1;
      wait_init("reinit_cycles");
      repeat (10) tick();
      check("no_stale", int'(rsp_valid), 0);
      send(1'b0, AW'(3), '0, s);
      wait_rsp(n);
      check("reinit_rd3", int'(rsp_data), 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
